// File: rtl/stru_pkg.sv
// Shared constants and the gate function for the stru pipelined gate network.
package stru_pkg;

    localparam int STAGES_DEFAULT = 2;
    localparam int STAGES_MIN     = 1;
    localparam int STAGES_MAX     = 8;
    // Wide enough to hold STAGES_MAX in the valid counter.
    localparam int CNT_W          = $clog2(STAGES_MAX + 1);

    function automatic logic gate_f(input logic a, input logic b, input logic c,
                                    input logic d, input logic e);
        return ((a & b) | (c & d)) ^ e;
    endfunction

endpackage

// File: rtl/stru_delay_line.sv
// Fixed-depth shift register; every stage clears asynchronously on rst.
module stru_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] line [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                line[i] <= '0;
            end
        end else begin
            line[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign q = line[DEPTH-1];

endmodule

// File: rtl/stru.sv
// Gate network f = ((a&b)|(c&d))^e registered through a STAGES-deep delay line,
// with a saturating counter that flags when y carries a sampled result.
module stru
    import stru_pkg::*;
#(
    parameter int STAGES = STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    output logic y,
    output logic y_valid
);

    generate
        if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
            $error("stru: STAGES must be within 1..8");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGES);

    logic             f;
    logic             tap;
    logic [CNT_W-1:0] cnt;

    // First delay-line stage is the sampling register, so a..e never reach y combinationally.
    assign f = gate_f(a, b, c, d, e);

    stru_delay_line #(
        .DEPTH(STAGES),
        .WIDTH(1)
    ) u_delay_line (
        .clk(clk),
        .rst(rst),
        .d  (f),
        .q  (tap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign y_valid = (cnt == CNT_LAST);
    assign y       = y_valid & tap;

endmodule

// File: tb/tb_stru.sv
// Directed bench for stru: three instances (STAGES = 2, 1, 8) share one stimulus stream.
module tb_stru;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
    logic y2, v2, y1, v1, y8, v8;

    int total = 0;
    int bad   = 0;

    // Hand-computed truth table: bit i = f for {a,b,c,d,e} = i.
    logic [31:0] tt = 32'h556A_6A6A;

    always #5 clk = ~clk;

    stru #(.STAGES(2)) dut2 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .y(y2), .y_valid(v2));
    stru #(.STAGES(1)) dut1 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .y(y1), .y_valid(v1));
    stru #(.STAGES(8)) dut8 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .y(y8), .y_valid(v8));

    task automatic drive(input logic [4:0] v);
        {a, b, c, d, e} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Holds rst over two edges, releases it 2 time units after an edge.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        drive(5'b11000);
        rst = 1'b1;
        #1;
        total++;
        if ({y2, v2, y1, v1, y8, v8} !== 6'b0) begin
            bad++;
            $display("FAIL reset_async got %b want 000000", {y2, v2, y1, v1, y8, v8});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({y2, v2, y1, v1, y8, v8} !== 6'b0) begin
                bad++;
                $display("FAIL reset_hold edge=%0d got %b want 000000", k, {y2, v2, y1, v1, y8, v8});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        drive(5'b11000);
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            logic w2, w1, w8;
            tick();
            w2 = (k >= 2);
            w1 = 1'b1;
            w8 = (k >= 8);
            total++;
            if ({y2, v2} !== {w2, w2}) begin
                bad++;
                $display("FAIL latency_s2 edge=%0d y,valid got %b%b want %b%b", k, y2, v2, w2, w2);
            end
            total++;
            if ({y1, v1} !== {w1, w1}) begin
                bad++;
                $display("FAIL latency_s1 edge=%0d y,valid got %b%b want %b%b", k, y1, v1, w1, w1);
            end
            total++;
            if ({y8, v8} !== {w8, w8}) begin
                bad++;
                $display("FAIL latency_s8 edge=%0d y,valid got %b%b want %b%b", k, y8, v8, w8, w8);
            end
        end
    endtask

    task automatic test_truth_table();
        int stg [3] = '{2, 1, 8};
        drive(5'b00000);
        do_reset();
        drive(5'd0);
        for (int k = 1; k <= 40; k++) begin
            logic [2:0] ys, vs;
            tick();
            ys = {y8, y1, y2};
            vs = {v8, v1, v2};
            for (int s = 0; s < 3; s++) begin
                logic wv, wy;
                int   j;
                wv = (k >= stg[s]);
                j  = k - stg[s];
                wy = (wv && j < 32) ? tt[j] : 1'b0;
                total++;
                if ({ys[s], vs[s]} !== {wy, wv}) begin
                    bad++;
                    $display("FAIL truth_s%0d edge=%0d y,valid got %b%b want %b%b",
                             stg[s], k, ys[s], vs[s], wy, wv);
                end
            end
            if (k < 32) drive(5'(k));
            else        drive(5'd0);
        end
    endtask

    task automatic test_back_to_back();
        drive(5'b00000);
        do_reset();
        drive(5'b11000);
        for (int k = 1; k <= 12; k++) begin
            logic w2, w1;
            tick();
            // Edge k samples 11000 when k is odd.
            w2 = (k >= 2) && ((k % 2) == 0);
            w1 = (k % 2) == 1;
            total++;
            if (y2 !== w2) begin
                bad++;
                $display("FAIL b2b_s2 edge=%0d y got %b want %b", k, y2, w2);
            end
            total++;
            if (y1 !== w1) begin
                bad++;
                $display("FAIL b2b_s1 edge=%0d y got %b want %b", k, y1, w1);
            end
            if (k >= 8) begin
                total++;
                if (y8 !== (k % 2 == 0)) begin
                    bad++;
                    $display("FAIL b2b_s8 edge=%0d y got %b want %b", k, y8, (k % 2 == 0));
                end
            end
            drive((k % 2) == 1 ? 5'b00000 : 5'b11000);
        end
    endtask

    task automatic test_mid_reset();
        drive(5'b11000);
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        total++;
        if ({y2, v2} !== 2'b11) begin
            bad++;
            $display("FAIL midrst_pre got %b%b want 11", y2, v2);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({y2, v2, y1, v1} !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_async got %b want 0000", {y2, v2, y1, v1});
        end
        drive(5'b00000);
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            logic w2v;
            tick();
            w2v = (k >= 2);
            total++;
            if ({y2, v2} !== {1'b0, w2v}) begin
                bad++;
                $display("FAIL midrst_post_s2 edge=%0d y,valid got %b%b want 0%b", k, y2, v2, w2v);
            end
            total++;
            if ({y1, v1} !== 2'b01) begin
                bad++;
                $display("FAIL midrst_post_s1 edge=%0d y,valid got %b%b want 01", k, y1, v1);
            end
        end
    endtask

    task automatic test_glitch();
        drive(5'b01000);
        do_reset();
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            a = 1'b1;
            #4;
            a = 1'b0;
            tick();
            total++;
            if ({y2, v2} !== 2'b01) begin
                bad++;
                $display("FAIL glitch_s2 cycle=%0d y,valid got %b%b want 01", k, y2, v2);
            end
            total++;
            if ({y1, v1} !== 2'b01) begin
                bad++;
                $display("FAIL glitch_s1 cycle=%0d y,valid got %b%b want 01", k, y1, v1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_truth_table();
        test_back_to_back();
        test_mid_reset();
        test_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stru.md
STRU -- requirements
Module: stru

Interface
REQ-001 Parameter: STAGES, default 2, clock cycles from input sample to y; legal range 1..8.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: a  input  1  logic operand A.
REQ-005 Port: b  input  1  logic operand B.
REQ-006 Port: c  input  1  logic operand C.
REQ-007 Port: d  input  1  logic operand D.
REQ-008 Port: e  input  1  logic operand E.
REQ-009 Port: y  output  1  delayed gate-network result.
REQ-010 Port: y_valid  output  1  high once y reflects a sampled input vector.

Function
REQ-011 Gate network SHALL compute f = ((a AND b) OR (c AND d)) XOR e, one bit, no other terms.
REQ-012 f SHALL be computed from a..e as sampled on a rising clk edge, with no combinational path from a..e to y.
REQ-013 y SHALL equal f of the inputs sampled exactly STAGES rising edges earlier (latency = STAGES cycles).
REQ-014 Delay line SHALL accept a new input vector every cycle with no stalls and no bubbles (throughput 1/cycle).
REQ-015 Input changes between edges SHALL have no effect; only the value present at each rising edge is used.
REQ-016 y_valid SHALL rise on the STAGES-th rising edge after rst deasserts and stay high until the next reset.
REQ-017 A cycle counter for y_valid SHALL saturate at STAGES and never wrap.
REQ-018 While y_valid is low, y SHALL be 0.
REQ-019 Unknown inputs (X/Z) are illegal; no output requirement applies while any input is X/Z.
REQ-020 STAGES = 1 SHALL give y = f of the previous edge's inputs and y_valid high after the first post-reset edge.

Reset
REQ-021 Asserting rst SHALL immediately, without waiting for clk, force y = 0, y_valid = 0, every delay-line stage = 0 and the counter = 0.
REQ-022 rst asserted mid-operation SHALL discard all in-flight results; none may appear on y after rst deasserts.
REQ-023 The first rising edge after rst deasserts SHALL sample a..e normally.
REQ-024 While rst is high, clock edges SHALL have no effect.

Structure
REQ-025 Package stru_pkg SHALL hold the STAGES default constant, the STAGES legal-range constants, and the gate function f.
REQ-026 The delay line SHALL be a separate sub-module, stru_delay_line, parameterised by depth and width.
REQ-027 The top level SHALL contain only the gate network, the valid counter and the stru_delay_line instance.
REQ-028 Elaboration SHALL fail if STAGES is outside 1..8.

Verification
REQ-029 Truth table: apply all 32 a..e vectors, one per cycle, STAGES=2 -> each y matches f two cycles later; e.g. a..e=0,1,0,1,0 -> y=0; 1,0,1,0,1 -> y=1; 0,0,0,0,1 -> y=1; 1,0,1,1,0 -> y=1; 0,1,0,0,0 -> y=0; 1,1,0,0,0 -> y=1.
REQ-030 Latency and valid: release rst, hold inputs 1,1,0,0,0 -> y_valid and y low for 1 edge, both high from edge 2 onward.
REQ-031 Back-to-back toggling: alternate vectors 1,1,0,0,0 and 0,0,0,0,0 every cycle -> y toggles 1,0,1,0 every cycle after a 2-cycle lag, with no gaps.
REQ-032 Mid-operation reset: assert rst asynchronously between edges with y=1 -> y=0 and y_valid=0 immediately; after release, no pre-reset value appears on y.
REQ-033 Glitch rejection: pulse a for less than one cycle between edges, other inputs b=1, c=d=e=0 -> y unaffected (stays 0).
REQ-034 Parameter sweep: STAGES=1 and STAGES=8 with the REQ-029 sequence -> latency 1 and 8 cycles respectively, with identical y values.
